// File: rtl/pclk_req_arbiter.sv
// pclk_req_arbiter: shares one pausible-clock mutex port (pc_req/pc_grant)
// among N requesters using a round-robin 4-phase handshake.
//
// Ports:
//   clock      free-running arbiter clock (rising edge)
//   rstn       asynchronous active-low reset
//   req[N]     per-requester 4-phase request (clock domain)
//   gnt[N]     per-requester grant, one-hot or zero
//   pc_req     request to the pausible-clock mutex
//   pc_grant   grant from the mutex (asynchronous to clock)
//   busy       high whenever the FSM is not idle
//   grant_cnt  completed grant cycles, saturating
//   pause_cnt  cycles with synchronised pc_grant high, saturating
module pclk_req_arbiter #(
  parameter int unsigned N           = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CW          = 16
) (
  input  logic          clock,
  input  logic          rstn,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic          pc_req,
  input  logic          pc_grant,
  output logic          busy,
  output logic [CW-1:0] grant_cnt,
  output logic [CW-1:0] pause_cnt
);

  localparam int unsigned PW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SCW = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_GRANT   = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          winner_q, winner_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [N-1:0]           gnt_d;
  logic                   pc_req_d;
  logic                   busy_d;
  logic                   grant_done;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   gs;
  logic [SCW-1:0]         settle_q;
  logic                   settled;
  logic                   rr_found;
  logic [PW-1:0]          rr_idx;
  logic [PW-1:0]          rr_cand;

  // pc_grant synchroniser; gs is the only view of the mutex the FSM uses
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], pc_grant};
  end
  assign gs = sync_q[SYNC_STAGES-1];

  // After reset the cleared chain reads low even if the mutex is still
  // granted; hold off arbitration until the chain has refilled.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn)         settle_q <= '0;
    else if (!settled) settle_q <= settle_q + SCW'(1);
  end
  assign settled = (settle_q == SCW'(SYNC_STAGES));

  // Round-robin search starting one past the last granted index
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    rr_cand  = ptr_q;
    for (int unsigned i = 1; i <= N; i++) begin
      rr_cand = PW'((32'(ptr_q) + i) % N);
      if (!rr_found && req[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      winner_q <= '0;
      ptr_q    <= PW'(N - 1);
      gnt      <= '0;
      pc_req   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      ptr_q    <= ptr_d;
      gnt      <= gnt_d;
      pc_req   <= pc_req_d;
      busy     <= busy_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    winner_d   = winner_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt;
    pc_req_d   = pc_req;
    grant_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        gnt_d    = '0;
        pc_req_d = 1'b0;
        // pc_req may only rise with the mutex seen released
        if (settled && !gs && rr_found) begin
          winner_d = rr_idx;
          pc_req_d = 1'b1;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        pc_req_d = 1'b1;
        if (gs) begin
          if (req[winner_q]) begin
            gnt_d   = N'(1) << winner_q;
            ptr_d   = winner_q;
            state_d = ST_GRANT;
          end else begin
            // requester withdrew: hand the mutex straight back
            pc_req_d = 1'b0;
            state_d  = ST_RELEASE;
          end
        end
      end
      ST_GRANT: begin
        // also bail out if the mutex drops grant unexpectedly
        if (!req[winner_q] || !gs) begin
          gnt_d      = '0;
          pc_req_d   = 1'b0;
          grant_done = 1'b1;
          state_d    = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        gnt_d    = '0;
        pc_req_d = 1'b0;
        if (!gs) state_d = ST_IDLE;
      end
      default: begin
        gnt_d    = '0;
        pc_req_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Saturating statistics counters
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      grant_cnt <= '0;
      pause_cnt <= '0;
    end else begin
      if (grant_done && (grant_cnt != '1)) grant_cnt <= grant_cnt + CW'(1);
      if (gs && (pause_cnt != '1))         pause_cnt <= pause_cnt + CW'(1);
    end
  end

endmodule
